sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Two-to-one arbiter that shares a single SRAM-like memory port between the instruction-fetch requester and the EXE-stage data requester. It grants one request per cycle, with data priority and a starvation guard for fetch. It records the owner of every accepted request in an in-order owner FIFO and routes each returning `data_ok`/`rdata` back to that owner. It sits between the IF/EXE stages and the memory bridge, and adds no latency to either path.

## Interface
- `OUTST_DEPTH`, default 4: maximum accepted-but-unanswered requests; power of two, ≥2.
- `STREAK_MAX`, default 4: number of consecutive data grants allowed while inst is waiting before inst is forced ahead.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `inst_req` in 1: fetch request valid.
- `inst_wr` in 1: fetch write flag; always 0 in practice but forwarded.
- `inst_size` in 2: fetch access size.
- `inst_wstrb` in 4: fetch byte strobes.
- `inst_addr` in 32: fetch address.
- `inst_wdata` in 32: fetch write data.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch response valid.
- `inst_rdata` out 32: fetch read data.
- `data_req` in 1: load/store request valid.
- `data_wr` in 1: load/store write flag.
- `data_size` in 2: load/store access size.
- `data_wstrb` in 4: load/store byte strobes.
- `data_addr` in 32: load/store address.
- `data_wdata` in 32: store data.
- `data_addr_ok` out 1: load/store request accepted.
- `data_data_ok` out 1: load/store response valid.
- `data_rdata` out 32: load read data.
- `bus_req` out 1: request to memory bridge.
- `bus_wr` out 1: write flag to bridge.
- `bus_size` out 2: access size to bridge.
- `bus_wstrb` out 4: byte strobes to bridge.
- `bus_addr` out 32: address to bridge.
- `bus_wdata` out 32: write data to bridge.
- `bus_addr_ok` in 1: bridge accepted request.
- `bus_data_ok` in 1: bridge response valid; responses return strictly in acceptance order.
- `bus_rdata` in 32: bridge read data.
- `err` out 1: sticky flag; set when `bus_data_ok` arrives with the owner FIFO empty.

## Operation
- **Grant** (combinational, per cycle):
  - `full` = (`count` == `OUTST_DEPTH`).
  - If `full`, no grant.
  - Otherwise, if only one requester is asserting, that requester is granted.
  - If both are asserting, data is granted unless `streak` == `STREAK_MAX`; in that case inst is granted.
- **Bus mux:** all `bus_*` request fields come from the granted requester. `bus_req` = grant exists. With no grant, the fields carry data-side values and `bus_req` = 0.
- **Accept routing:** `inst_addr_ok` = `bus_addr_ok` & `bus_req` & inst granted. `data_addr_ok` is the same for data. The requester that is not granted sees `addr_ok` = 0 and must hold its request.
- **Owner FIFO:** `OUTST_DEPTH` entries × 1 bit (0 = inst, 1 = data), with `wptr`, `rptr` and a `count` of log2(`OUTST_DEPTH`)+1 bits.
  - Push the owner on handshake (`bus_req` & `bus_addr_ok`).
  - Pop on `bus_data_ok` when `count` ≠ 0.
  - Pointers wrap modulo `OUTST_DEPTH`.
  - Simultaneous push and pop leaves `count` unchanged. This is legal at any non-full count. At full, no push can occur because `bus_req` = 0.
- **Response routing:**
  - `inst_data_ok` = `bus_data_ok` & (`count` ≠ 0) & head == 0.
  - `data_data_ok` = `bus_data_ok` & (`count` ≠ 0) & head == 1.
  - `inst_rdata` = `data_rdata` = `bus_rdata`. They are unqualified; consumers must qualify them with their own `data_ok`.
- **Streak counter** (0..`STREAK_MAX`):
  - Increment (saturating) on a data handshake when `inst_req` is also asserted.
  - Clear on any inst handshake.
  - Clear in any cycle where `inst_req` = 0.
  - Otherwise hold.
- **Error:** `bus_data_ok` with `count` = 0 sets `err`, pops nothing and asserts no `data_ok`. Only `reset` clears `err`.

## Timing
- **Reset values:** `count` = 0, `wptr` = `rptr` = 0, `streak` = 0, `err` = 0. With requests low, `bus_req` and all `addr_ok`/`data_ok` outputs are 0.
- **Zero added latency:**
  - `addr_ok` is combinational from `bus_addr_ok` in the same cycle.
  - `data_ok` is combinational from `bus_data_ok` and the registered FIFO head.
- A request accepted in cycle N can receive `data_ok` no earlier than cycle N+1, since the FIFO push is visible at N+1.
- **Full:** `bus_req` drops in the cycle after the push that makes `count` = `OUTST_DEPTH`. It reasserts in the cycle after the first pop.
- **Reset mid-operation:** all outstanding ownership is discarded. The bridge is reset by the same `reset`, so no stale `data_ok` follows. If one does arrive, `err` is set.
- **No combinational paths** from `bus_addr_ok` or `bus_data_ok` into grant selection.

## Test plan
- **Idle:** assert `reset`, then release with no requests → `bus_req` = 0, all `ok` outputs = 0, `err` = 0.
- **Contention:** both `req` = 1, `bus_addr_ok` = 1 constantly, `bus_data_ok` answers after 1 cycle, depth 4 → data granted 4 handshakes, then inst 1, then data resumes; every `data_ok` goes to the matching owner in order.
- **Fill:** `data_req` only, `bus_addr_ok` = 1, `bus_data_ok` held 0 → exactly 4 `data_addr_ok` pulses, then `bus_req` = 0. A single `bus_data_ok` → `data_data_ok` = 1 and one further acceptance the cycle after.
- **Interleave:** accept inst@0x1c000000, data@0x80 (rd), inst@0x1c000004; then return rdata 0x11, 0x22, 0x33 → `inst_data_ok` for 0x11, `data_data_ok` for 0x22, `inst_data_ok` for 0x33.
- **Push/pop same cycle:** at `count` = 2, a handshake and a `bus_data_ok` in the same cycle → `count` stays 2 and the pointer wrap is correct across 10 iterations.
- **Spurious response, then reset:** `bus_data_ok` while empty → `err` = 1, no `data_ok`. Reset with 3 requests outstanding → `count` = 0, `err` = 0 the next cycle.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like port between instruction fetch and
// EXE-stage data. Data has priority; an in-order owner FIFO routes responses back.
module sram_req_arbiter #(
   parameter int unsigned OUTST_DEPTH = 4,
   parameter int unsigned STREAK_MAX  = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,

   output logic        err
);

   localparam int unsigned PTR_W = $clog2(OUTST_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STK_W = $clog2(STREAK_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(OUTST_DEPTH);
   localparam logic [STK_W-1:0] STK_LIMIT  = STK_W'(STREAK_MAX);
   localparam logic             OWNER_INST = 1'b0;
   localparam logic             OWNER_DATA = 1'b1;

   logic [PTR_W-1:0]       wptr_q, wptr_d;
   logic [PTR_W-1:0]       rptr_q, rptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [STK_W-1:0]       streak_q, streak_d;
   logic                   err_q, err_d;
   logic [OUTST_DEPTH-1:0] owner_q;

   logic full;
   logic fifo_empty;
   logic inst_forced;
   logic grant_inst;
   logic grant_data;
   logic handshake;
   logic pop;
   logic spurious;
   logic head_owner;

   // Grant depends only on requests and registered state, never on bus_*_ok.
   assign full        = (count_q == CNT_FULL);
   assign fifo_empty  = (count_q == '0);
   assign inst_forced = inst_req && (streak_q == STK_LIMIT);
   assign grant_data  = !full && data_req && !inst_forced;
   assign grant_inst  = !full && inst_req && (!data_req || inst_forced);

   assign bus_req   = grant_inst || grant_data;
   assign bus_wr    = grant_inst ? inst_wr    : data_wr;
   assign bus_size  = grant_inst ? inst_size  : data_size;
   assign bus_wstrb = grant_inst ? inst_wstrb : data_wstrb;
   assign bus_addr  = grant_inst ? inst_addr  : data_addr;
   assign bus_wdata = grant_inst ? inst_wdata : data_wdata;

   assign handshake    = bus_req && bus_addr_ok;
   assign inst_addr_ok = handshake && grant_inst;
   assign data_addr_ok = handshake && grant_data;

   assign head_owner   = owner_q[rptr_q];
   assign pop          = bus_data_ok && !fifo_empty;
   assign spurious     = bus_data_ok && fifo_empty;
   assign inst_data_ok = pop && (head_owner == OWNER_INST);
   assign data_data_ok = pop && (head_owner == OWNER_DATA);
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;
   assign err          = err_q;

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      streak_d = streak_q;
      err_d    = err_q;

      if (handshake) wptr_d = wptr_q + PTR_W'(1);
      if (pop)       rptr_d = rptr_q + PTR_W'(1);

      if (handshake && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !handshake) begin
         count_d = count_q - CNT_W'(1);
      end

      // Streak only measures data grants that actually made inst wait.
      if (!inst_req) begin
         streak_d = '0;
      end else if (handshake && grant_inst) begin
         streak_d = '0;
      end else if (handshake && grant_data && (streak_q != STK_LIMIT)) begin
         streak_d = streak_q + STK_W'(1);
      end

      if (spurious) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         streak_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         streak_q <= streak_d;
         err_q    <= err_d;
      end
   end

   // Owner storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (handshake) owner_q[wptr_q] <= grant_data;
   end

endmodule
